// File: rtl/hist_seq_pkg.sv
// hist_seq_pkg: shared state encoding, sizes and reset thresholds for the histogram frame sequencer.
package hist_seq_pkg;
  localparam int NUM_BINS = 256;
  localparam int BIN_W_DEF = 20;
  localparam int ADDR_W_DEF = 8;
  localparam logic [7:0] THR25_RST = 8'd64;
  localparam logic [7:0] THR50_RST = 8'd128;
  localparam logic [7:0] THR75_RST = 8'd192;
  typedef enum logic [2:0] {INIT, IDLE, ACCUM, CUMSUM, CLEAR} state_t;
endpackage

// File: rtl/hist_quartile_finder.sv
// hist_quartile_finder: quartile targets and first-hit capture of the lowest bin whose cumulative sum reaches each target.
module hist_quartile_finder
  import hist_seq_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              hit_en,
  input  logic [ADDR_W-1:0] bin,
  input  logic [BIN_W-1:0]  cum,
  input  logic [BIN_W-1:0]  count,
  output logic [ADDR_W-1:0] t25,
  output logic [ADDR_W-1:0] t50,
  output logic [ADDR_W-1:0] t75
);
  logic [BIN_W-1:0] tgt [3];
  logic [ADDR_W-1:0] thr_nx [3];
  assign tgt[0] = count >> 2;
  assign tgt[1] = count >> 1;
  assign tgt[2] = tgt[0] + tgt[1];
  // thr_nx already includes the current bin so the final bin counts in the exit cycle
  for (genvar i = 0; i < 3; i++) begin : g_q
    logic found, hit;
    logic [ADDR_W-1:0] thr;
    assign hit = hit_en && !found && cum >= tgt[i];
    assign thr_nx[i] = hit ? bin : thr;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        found <= 1'b0;
        thr <= '0;
      end else begin
        found <= !clr && (found || hit);
        thr <= clr ? '0 : thr_nx[i];
      end
    end
  end
  assign t25 = thr_nx[0];
  assign t50 = thr_nx[1];
  assign t75 = thr_nx[2];
endmodule

// File: rtl/hist_frame_sequencer.sv
// hist_frame_sequencer: sequences bin RAM clear, accumulate and cumulative-sum passes per frame and derives quartile thresholds.
// Define HIST_SEQ_MAX_TRACK_EN to scale the display by the largest bin instead of the pixel count.
module hist_frame_sequencer
  import hist_seq_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iFval,
  input  logic              iGrayValid,
  input  logic [ADDR_W-1:0] iDispAddr,
  input  logic [BIN_W-1:0]  iRamRdData,
  output logic [ADDR_W-1:0] oRamRdAddr,
  output logic              oRamWrEn,
  output logic [ADDR_W-1:0] oRamWrAddr,
  output logic [BIN_W-1:0]  oRamWrData,
  output logic              oCumWrEn,
  output logic [ADDR_W-1:0] oCumWrAddr,
  output logic [BIN_W-1:0]  oCumWrData,
  output logic              oAccumEn,
  output logic              oDispGrant,
  output logic [7:0]        oThresh25,
  output logic [7:0]        oThresh50,
  output logic [7:0]        oThresh75,
  output logic [BIN_W-1:0]  oMaxValue,
  output logic              oDone,
  output logic              oOverrun
);
  localparam logic [ADDR_W:0] CUM_LAST = (ADDR_W+1)'(1 << ADDR_W);
  state_t state, state_nx;
  logic fval_q, rise, fall, grant, sweep, sweep_last, rd_valid, cum_exit;
  logic [ADDR_W:0] cnt;
  logic [ADDR_W-1:0] bin, q25, q50, q75;
  logic [BIN_W-1:0] count, cum, cum_nx, max_nx;
  assign rise = iFval & ~fval_q;
  assign fall = ~iFval & fval_q;
  assign grant = state == IDLE || state == ACCUM;
  assign sweep = state == INIT || state == CLEAR;
  assign sweep_last = sweep && &cnt[ADDR_W-1:0];
  // read data lags the address by one cycle, so bin k arrives while cnt is k+1
  assign rd_valid = state == CUMSUM && cnt != '0;
  assign cum_exit = state == CUMSUM && cnt == CUM_LAST;
  assign bin = cnt[ADDR_W-1:0] - 1'b1;
  assign cum_nx = cum + iRamRdData;
  assign oAccumEn = state == ACCUM;
  assign oDispGrant = grant;
  assign oRamRdAddr = grant ? iDispAddr : cnt[ADDR_W-1:0];
  assign oRamWrData = '0;
  assign oCumWrData = cum;
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= INIT;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      INIT, CLEAR: if (sweep_last) state_nx = IDLE;
      IDLE:        if (rise) state_nx = ACCUM;
      ACCUM:       if (fall) state_nx = CUMSUM;
      CUMSUM:      if (cum_exit) state_nx = CLEAR;
      default:     state_nx = INIT;
    endcase
  end
  hist_quartile_finder #(.BIN_W(BIN_W), .ADDR_W(ADDR_W)) u_quartile (
    .clk(iClk),
    .rst_n(iRst_n),
    .clr(state != CUMSUM),
    .hit_en(rd_valid),
    .bin(bin),
    .cum(cum_nx),
    .count(count),
    .t25(q25),
    .t50(q50),
    .t75(q75)
  );
`ifdef HIST_SEQ_MAX_TRACK_EN
  logic [BIN_W-1:0] bin_max;
  assign max_nx = (rd_valid && iRamRdData > bin_max) ? iRamRdData : bin_max;
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) bin_max <= '0;
    else bin_max <= state == CUMSUM ? max_nx : '0;
  end
`else
  assign max_nx = count;
`endif
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      fval_q <= 1'b0;
      cnt <= '0;
      count <= '0;
      cum <= '0;
      oCumWrEn <= 1'b0;
      oCumWrAddr <= '0;
      oRamWrEn <= 1'b0;
      oRamWrAddr <= '0;
      oDone <= 1'b0;
      oOverrun <= 1'b0;
      oThresh25 <= THR25_RST;
      oThresh50 <= THR50_RST;
      oThresh75 <= THR75_RST;
      oMaxValue <= BIN_W'(1);
    end else begin
      fval_q <= iFval;
      cnt <= (state_nx != state || grant) ? '0 : cnt + 1'b1;
      if (state == IDLE && rise) count <= '0;
      else if (state == ACCUM && iGrayValid && !(&count)) count <= count + 1'b1;
      cum <= state != CUMSUM ? '0 : rd_valid ? cum_nx : cum;
      oCumWrEn <= rd_valid;
      oCumWrAddr <= bin;
      oRamWrEn <= sweep;
      oRamWrAddr <= cnt[ADDR_W-1:0];
      oDone <= state == CLEAR && sweep_last;
      oOverrun <= rise && !grant;
      if (cum_exit) begin
        oThresh25 <= 8'(q25);
        oThresh50 <= 8'(q50);
        oThresh75 <= 8'(q75);
        oMaxValue <= max_nx == '0 ? BIN_W'(1) : max_nx;
      end
    end
  end
endmodule
